text_console_writer: RTL and testbench
======================================

// Module: text_console_writer
// PURPOSE
//  Writer side of the text-mode screen memory: turns a stream of ASCII bytes into
//  CPU-style bus writes to the character RAM (VRAM_BASE) and attribute RAM (ATTR_BASE)
//  that the HDMI video controller scans out. It keeps a cursor, handles control codes
//  and wraps the screen teletype-style. It sits beside the CPU on the system bus behind
//  a req/gnt arbiter and is used for boot and debug text output.
// PARAMETERS
//  VRAM_BASE  16'hE800  base address of the character-code RAM (COLS*ROWS bytes)
//  ATTR_BASE  16'hE000  base address of the attribute RAM (same layout)
//  COLS       64        columns per row (power of 2)
//  ROWS       32        rows per screen (power of 2)
//  WR_LEN     2         WR low time in clocks, >=1
//  BLANK      8'h20     character code used for clearing
// PORTS
//  clk        in   1   system clock; all logic on its rising edge
//  rst        in   1   asynchronous reset, active low
//  ch_data    in   8   ASCII byte to print
//  ch_attr    in   8   attribute for this byte (colour/underline bits as in ATTR RAM)
//  ch_valid   in   1   ch_data/ch_attr valid
//  ch_ready   out  1   block can accept; transfer on ch_valid & ch_ready at a clk edge
//  bus_req    out  1   request for system bus ownership
//  bus_gnt    in   1   bus granted by the arbiter
//  ADD        out  16  bus address
//  DOUT       out  8   bus write data
//  WR         out  1   write strobe, active low (memory captures while low)
//  cur_col    out  6   cursor column (log2 COLS)
//  cur_row    out  5   cursor row (log2 ROWS)
// BEHAVIOUR
//  Reset (async, immediate): ADD=0, DOUT=0, WR=1, bus_req=0, ch_ready=0, cursor=(0,0),
//   FSM=IDLE. ch_ready rises on the first clock after reset release. Reset during a write
//   forces WR high at once; no partial cycle resumes.
//  Cell address: pos = row*COLS + col; char at VRAM_BASE+pos, attr at ATTR_BASE+pos.
//  Write cycle (one byte): SETUP 1 clk (ADD/DOUT driven, WR=1) -> STROBE WR_LEN clk
//   (WR=0) -> HOLD 1 clk (WR=1, ADD/DOUT unchanged) = WR_LEN+2 clk. bus_gnt is sampled only
//   when entering SETUP; if low, wait with WR=1. ADD/DOUT never change while WR=0.
//  FSM: IDLE (ch_ready=1) -accept-> REQ (bus_req=1, wait gnt) -> DECODE -> one of:
//   PRINT: write char, then attr, at cursor; col+1; if col was COLS-1: col=0, NEWLINE.
//   0x0D CR: col=0, no writes.   0x08 BS: col-1 if col>0, no writes, no erase.
//   0x0A LF: NEWLINE.   0x0C FF: CLR_ALL, then cursor=(0,0).
//   other codes 0x00-0x1F: ignored, no writes.
//   NEWLINE: row=(row+1) mod ROWS (row ROWS-1 wraps to 0); then CLR_ROW on the new row.
//   CLR_ROW: COLS cells, col 0..COLS-1, each BLANK char then ch_attr; col unchanged.
//   CLR_ALL: all COLS*ROWS cells in ascending pos, each BLANK then ch_attr.
//   After last write -> RELEASE (bus_req=0 for 1 clk) -> IDLE.
//  bus_req rises in REQ and stays high until RELEASE, even for codes with no writes.
//  ch_ready=0 in every state except IDLE; ch_data/ch_attr are registered at accept.
//  Latency with bus_gnt held high: printable byte not at end of row -> ch_ready high again
//   2*(WR_LEN+2)+3 clk after the accept edge (11 clk at WR_LEN=2); CR/BS -> 3 clk.
//  Cursor counters wrap in their own width; pos arithmetic is modulo COLS*ROWS.
// TESTING
//  1 Reset, cursor (0,0), gnt=1, send 'A'(0x41) attr 0x07 -> WR pulses: E800<=41,
//    E000<=07, each WR low 2 clk; cur_col=1; ch_ready high after 11 clk.
//  2 Cursor (63,5), send 0x42 -> write at E800+0x17F, then cursor (0,6) and 128 writes
//    clearing E800+0x180..0x1BF to 0x20 plus matching attr cells; col stays 0.
//  3 Cursor (10,31), send 0x0A -> row 0, E800..E83F cleared, cur_col=10.
//  4 Send 0x0C attr 0x70 -> 4096 writes covering E800..EFFF=0x20, E000..E7FF=0x70,
//    cursor (0,0); 0x0D / 0x08 at col 0 -> no WR pulse, cursor unchanged.
//  5 Hold bus_gnt=0 for 20 clk after bus_req -> WR stays 1, ADD stable; gnt=1 -> write
//    proceeds; drop gnt between char and attr writes -> attr write waits in SETUP.
//  6 Assert rst while WR=0 in a CLR_ALL -> WR=1, bus_req=0, cursor (0,0) same cycle.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer: turns a byte stream into character/attribute RAM bus
// writes for the text-mode screen. Keeps a teletype cursor, honours CR, BS,
// LF and FF, clears the new row on every line feed, and owns the system bus
// through a req/gnt handshake for the whole lifetime of one byte.
module text_console_writer #(
  parameter logic [15:0] VRAM_BASE = 16'hE800,
  parameter logic [15:0] ATTR_BASE = 16'hE000,
  parameter int          COLS      = 64,
  parameter int          ROWS      = 32,
  parameter int          WR_LEN    = 2,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                ch_data,
  input  logic [7:0]                ch_attr,
  input  logic                      ch_valid,
  output logic                      ch_ready,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output logic [15:0]               ADD,
  output logic [7:0]                DOUT,
  output logic                      WR,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   cur_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int PW    = CW + RW;
  localparam int CELLS = COLS * ROWS;
  localparam int SW    = $clog2(WR_LEN + 1);

  localparam logic [7:0] C_BS = 8'h08;
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_FF = 8'h0C;
  localparam logic [7:0] C_CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DECODE, S_WAIT_GNT, S_SETUP, S_STROBE, S_HOLD, S_RELEASE
  } state_t;

  // What the current run of bus writes is doing.
  typedef enum logic [1:0] {J_PRINT, J_ROW, J_ALL} job_t;

  state_t          state, state_n;
  job_t            job, job_n;
  logic [PW-1:0]   cnt, cnt_n;      // cell index within a clear run
  logic            phase, phase_n;  // 0: char write, 1: attr write of same cell
  logic [CW-1:0]   col, col_n;
  logic [RW-1:0]   row, row_n;
  logic [SW-1:0]   stb_cnt;
  logic [7:0]      data_r, attr_r;
  logic [PW-1:0]   pos_n;
  logic [15:0]     addr_n;
  logic [7:0]      wdata_n;

  logic accept, printable, needs_write, stb_last, last_write;

  assign accept      = ch_valid & ch_ready;
  assign printable   = (data_r >= 8'h20);
  assign needs_write = printable || (data_r == C_LF) || (data_r == C_FF);
  assign stb_last    = (stb_cnt == SW'(WR_LEN - 1));
  // The attr write of the final cell ends the run; a print at the last column
  // instead rolls into clearing the next row.
  assign last_write  = phase && (((job == J_PRINT) && !(&col)) ||
                                 ((job == J_ROW) && (cnt == PW'(COLS - 1))) ||
                                 ((job == J_ALL) && (cnt == PW'(CELLS - 1))));

  assign cur_col = col;
  assign cur_row = row;

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic; bus_gnt is consulted only on the way into SETUP (and to leave REQ).
  // NOTE: state_n gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (accept) state_n = S_REQ;
      S_REQ:      if (bus_gnt) state_n = S_DECODE;
      S_DECODE:   if (!needs_write)  state_n = S_RELEASE;
                  else if (bus_gnt)  state_n = S_SETUP;
                  else               state_n = S_WAIT_GNT;
      S_WAIT_GNT: if (bus_gnt) state_n = S_SETUP;
      S_SETUP:    state_n = S_STROBE;
      S_STROBE:   if (stb_last) state_n = S_HOLD;
      S_HOLD:     if (last_write)   state_n = S_RELEASE;
                  else if (bus_gnt) state_n = S_SETUP;
                  else              state_n = S_WAIT_GNT;
      S_RELEASE:  state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Cursor and write-pointer next values: set up in DECODE, advanced as each write finishes.
  always_comb begin
    job_n   = job;
    cnt_n   = cnt;
    phase_n = phase;
    col_n   = col;
    row_n   = row;
    case (state)
      S_DECODE: begin
        phase_n = 1'b0;
        cnt_n   = '0;
        if (printable) job_n = J_PRINT;
        else begin
          case (data_r)
            C_LF: begin
              row_n = row + RW'(1);
              job_n = J_ROW;
            end
            C_FF: job_n = J_ALL;
            C_CR: col_n = '0;
            C_BS: if (col != '0) col_n = col - CW'(1);
            default: ;
          endcase
        end
      end
      S_HOLD: begin
        if (!phase) phase_n = 1'b1;
        else begin
          phase_n = 1'b0;
          cnt_n   = cnt + PW'(1);
          case (job)
            J_PRINT: begin
              col_n = col + CW'(1);
              if (&col) begin
                row_n = row + RW'(1);
                job_n = J_ROW;
                cnt_n = '0;
              end
            end
            J_ALL: if (cnt == PW'(CELLS - 1)) begin
              col_n = '0;
              row_n = '0;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Address and data of the write that the next SETUP will present.
  always_comb begin
    case (job_n)
      J_PRINT: pos_n = {row_n, col_n};
      J_ROW:   pos_n = {row_n, cnt_n[CW-1:0]};
      default: pos_n = cnt_n;
    endcase
    addr_n  = (phase_n ? ATTR_BASE : VRAM_BASE) + 16'(pos_n);
    wdata_n = phase_n ? attr_r : ((job_n == J_PRINT) ? data_r : BLANK);
  end

  // Datapath registers and registered bus/handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job      <= J_PRINT;
      cnt      <= '0;
      phase    <= 1'b0;
      col      <= '0;
      row      <= '0;
      stb_cnt  <= '0;
      data_r   <= '0;
      attr_r   <= '0;
      ADD      <= '0;
      DOUT     <= '0;
      WR       <= 1'b1;
      bus_req  <= 1'b0;
      ch_ready <= 1'b0;
    end else begin
      job   <= job_n;
      cnt   <= cnt_n;
      phase <= phase_n;
      col   <= col_n;
      row   <= row_n;
      if (accept) begin
        data_r <= ch_data;
        attr_r <= ch_attr;
      end
      stb_cnt <= (state == S_STROBE) ? stb_cnt + SW'(1) : '0;
      // ADD/DOUT only move on entry to SETUP, so they are frozen through STROBE and HOLD.
      if (state_n == S_SETUP) begin
        ADD  <= addr_n;
        DOUT <= wdata_n;
      end
      WR       <= (state_n != S_STROBE);
      bus_req  <= (state_n != S_IDLE) && (state_n != S_RELEASE);
      ch_ready <= (state_n == S_IDLE);
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed screen scenarios plus random byte
// streams, compared against a cursor/screen model that lists the expected
// bus writes straight from the teletype rules.
module tb_text_console_writer;

  localparam int COLS = 64, ROWS = 32, WR_LEN = 2, CELLS = COLS * ROWS;
  localparam logic [15:0] VRAM = 16'hE800, ATTR = 16'hE000;

  typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  ch_data = 8'h00, ch_attr = 8'h00;
  logic        ch_valid = 1'b0, bus_gnt = 1'b1;
  logic        ch_ready, bus_req, WR;
  logic [15:0] ADD;
  logic [7:0]  DOUT;
  logic [5:0]  cur_col;
  logic [4:0]  cur_row;

  text_console_writer dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_attr(ch_attr), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .bus_req(bus_req), .bus_gnt(bus_gnt), .ADD(ADD), .DOUT(DOUT),
    .WR(WR), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Arbiter: fixed level, or random grants when gnt_rand is set.
  logic gnt_rand = 1'b0, gnt_val = 1'b1;
  initial forever begin
    @(negedge clk);
    bus_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : gnt_val;
  end

  // Bus monitor: records every completed WR pulse and counts protocol errors
  // (ADD/DOUT not set up before, stable during and held after WR low; pulse width).
  wr_t         got_q[$];
  int          mon_err = 0;
  logic        in_low = 1'b0;
  wr_t         cap;
  int          low_cnt = 0;
  logic [15:0] prev_add = '0;
  logic [7:0]  prev_dout = '0;
  initial forever begin
    @(posedge clk); #1;
    if (!rst) in_low = 1'b0;
    else if (!WR) begin
      if (!in_low) begin
        if (ADD !== prev_add || DOUT !== prev_dout) mon_err++;
        cap = {ADD, DOUT}; low_cnt = 1; in_low = 1'b1;
      end else begin
        low_cnt++;
        if ({ADD, DOUT} !== cap) mon_err++;
      end
    end else if (in_low) begin
      if ({ADD, DOUT} !== cap || low_cnt != WR_LEN) mon_err++;
      got_q.push_back(cap);
      in_low = 1'b0;
    end
    prev_add = ADD; prev_dout = DOUT;
  end

  // Reference model: cursor plus the ordered list of writes each byte must cause.
  wr_t exp_q[$];
  int  mcol = 0, mrow = 0;
  wr_t g_first, g_last;

  function automatic void push_cell(int pos, logic [7:0] c, logic [7:0] a);
    exp_q.push_back({VRAM + 16'(pos), c});
    exp_q.push_back({ATTR + 16'(pos), a});
  endfunction

  function automatic void model_newline(logic [7:0] a);
    mrow = (mrow + 1) % ROWS;
    for (int c = 0; c < COLS; c++) push_cell(mrow * COLS + c, 8'h20, a);
  endfunction

  function automatic void model_char(logic [7:0] d, logic [7:0] a);
    if (d >= 8'h20) begin
      push_cell(mrow * COLS + mcol, d, a);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        model_newline(a);
      end
    end else if (d == 8'h0D) mcol = 0;
    else if (d == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (d == 8'h0A) model_newline(a);
    else if (d == 8'h0C) begin
      for (int p = 0; p < CELLS; p++) push_cell(p, 8'h20, a);
      mcol = 0; mrow = 0;
    end
  endfunction

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 255));
  endfunction

  task automatic accept(input logic [7:0] d, input logic [7:0] a);
    bit ok = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    for (int i = 0; i < 30000 && !ok; i++) begin
      @(negedge clk);
      if (ch_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      report();
    end
    ch_data = d; ch_attr = a; ch_valid = 1'b1;
    @(posedge clk); #1;
    ch_valid = 1'b0; ch_data = 8'($urandom); ch_attr = 8'($urandom);
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    for (int i = 1; i <= 30000 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (ch_ready) lat = i;
    end
    if (lat == 0) begin
      check("ready_timeout", 0, 1);
      report();
    end
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_col"}, cur_col, mcol);
    check({tag, "_row"}, cur_row, mrow);
    check({tag, "_proto"}, mon_err, 0);
    g_first = (got_q.size() > 0) ? got_q[0] : '0;
    g_last  = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
    got_q.delete(); exp_q.delete(); mon_err = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a, input bit chk_lat, input string tag);
    int lat, nw;
    model_char(d, a);
    nw = exp_q.size();
    accept(d, a);
    wait_ready(lat);
    if (chk_lat) check({tag, "_lat"}, lat, (nw == 0) ? 3 : nw * (WR_LEN + 2) + 3);
    compare(tag);
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    logic [7:0] c;
    r = $urandom_range(0, 99);
    if (r < 70)      return rand_print();
    else if (r < 78) return 8'h0D;
    else if (r < 86) return 8'h08;
    else if (r < 92) return 8'h0A;
    c = 8'($urandom_range(0, 31));
    if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
    return c;
  endfunction

  initial begin
    int lat;
    bit held;
    logic [15:0] a0;

    // Reset state.
    #12;
    check("rst_add", ADD, 16'h0);   check("rst_dout", DOUT, 8'h0);
    check("rst_wr", WR, 1'b1);      check("rst_req", bus_req, 1'b0);
    check("rst_ready", ch_ready, 1'b0);
    check("rst_col", cur_col, 0);   check("rst_row", cur_row, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_rise", ch_ready, 1'b1);

    // 'A' at (0,0).
    send(8'h41, 8'h07, 1'b1, "t1");
    check("t1_w0", g_first, {16'hE800, 8'h41});
    check("t1_w1", g_last, {16'hE000, 8'h07});

    // Form feed, then CR/BS at column 0.
    send(8'h0C, 8'h70, 1'b1, "t4_ff");
    check("t4_first", g_first, {16'hE800, 8'h20});
    check("t4_last", g_last, {16'hE7FF, 8'h70});
    send(8'h0D, 8'h11, 1'b1, "t4_cr");
    send(8'h08, 8'h22, 1'b1, "t4_bs");

    // Print at (63,5): wraps to row 6 and clears it.
    for (int i = 0; i < 5; i++) send(8'h0A, 8'($urandom), 1'b1, "t2_lf");
    for (int i = 0; i < 63; i++) send(rand_print(), 8'($urandom), 1'b1, "t2_fill");
    send(8'h42, 8'h1E, 1'b1, "t2");
    check("t2_first", g_first, {16'hE97F, 8'h42});

    // LF at (10,31) wraps to row 0.
    for (int i = 0; i < 10; i++) send(rand_print(), 8'($urandom), 1'b1, "t3_fill");
    for (int i = 0; i < 25; i++) send(8'h0A, 8'($urandom), 1'b1, "t3_lf");
    send(8'h0A, 8'h3C, 1'b1, "t3");
    check("t3_first", g_first, {16'hE800, 8'h20});

    // Grant withheld before the first write and between char and attr writes.
    gnt_val = 1'b0;
    repeat (2) @(negedge clk);
    model_char(8'h58, 8'h1F);
    accept(8'h58, 8'h1F);
    held = 1'b1; a0 = ADD;
    repeat (20) begin
      @(posedge clk); #1;
      if (!WR || !bus_req || ADD !== a0) held = 1'b0;
    end
    check("t5_gnt_wait", held, 1'b1);
    check("t5_no_wr", got_q.size(), 0);
    gnt_val = 1'b1;
    for (int i = 0; i < 50 && got_q.size() == 0; i++) begin
      @(posedge clk); #2;
    end
    gnt_val = 1'b0;
    a0 = ADD; held = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!WR || !bus_req || ADD !== a0) held = 1'b0;
    end
    check("t5_attr_wait", held, 1'b1);
    check("t5_one_wr", got_q.size(), 1);
    gnt_val = 1'b1;
    wait_ready(lat);
    compare("t5");

    // Random streams: steady grant with latency checks, then a random arbiter.
    for (int i = 0; i < 40; i++) send(rand_code(), 8'($urandom), 1'b1, $sformatf("rnd%0d", i));
    gnt_rand = 1'b1;
    for (int i = 0; i < 30; i++) send(rand_code(), 8'($urandom), 1'b0, $sformatf("rgnt%0d", i));
    gnt_rand = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a screen clear.
    send(8'h5A, 8'h0F, 1'b1, "t6_pre");
    accept(8'h0C, 8'h55);
    repeat (200) @(posedge clk);
    held = 1'b0;
    for (int i = 0; i < 20 && !held; i++) begin
      @(posedge clk); #1;
      if (!WR) held = 1'b1;
    end
    check("t6_in_strobe", held, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_wr", WR, 1'b1);        check("t6_req", bus_req, 1'b0);
    check("t6_col", cur_col, 0);     check("t6_row", cur_row, 0);
    check("t6_ready", ch_ready, 1'b0);
    repeat (2) @(posedge clk);
    got_q.delete(); exp_q.delete(); mon_err = 0; mcol = 0; mrow = 0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("t6_ready_rise", ch_ready, 1'b1);
    send(8'h51, 8'h2A, 1'b1, "t6_post");
    check("t6_post_w0", g_first, {16'hE800, 8'h51});

    report();
  end

endmodule
